// File: rtl/usbl_tx_pkg.sv
// Shared definitions for the USBL transmit path: ping FSM states and default counter sizing.
package usbl_tx_pkg;

  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned DEAD_CYC_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

endpackage

// File: rtl/ping_burst_gen_if.sv
// Control/status and transducer-drive bundle between a ping controller and ping_burst_gen.
interface ping_burst_gen_if #(
  parameter int unsigned CNT_W = usbl_tx_pkg::CNT_W_DEF
);
  logic             start;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W-1:0] n_cycles;
  logic [CNT_W-1:0] guard;
  logic             busy;
  logic             done;
  logic             drv_a;
  logic             drv_b;

  modport master (
    output start, half_period, n_cycles, guard,
    input  busy, done, drv_a, drv_b
  );

  modport slave (
    input  start, half_period, n_cycles, guard,
    output busy, done, drv_a, drv_b
  );
endinterface

// File: rtl/cnt_dn.sv
// Loadable down-counter that saturates at zero and flags when it holds zero.
module cnt_dn #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/ping_burst_gen.sv
// One acoustic ping: gated square-wave carrier on drv_a/drv_b, then a guard interval.
// Define PING_DEADTIME_EN to blank the first DEAD_CYC clocks of every half-period.
module ping_burst_gen
  import usbl_tx_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
`ifdef PING_DEADTIME_EN
  , parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  ping_burst_gen_if.slave bus
);

  state_e           state_q, state_d;
  logic             phase_b_q, phase_b_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] guard_q, guard_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drv_a_q, drv_a_d;
  logic             drv_b_q, drv_b_d;

  logic             t_load, t_dec, t_zero_c;
  logic [CNT_W-1:0] t_val;
  logic             c_load, c_dec, c_zero_c;
  logic [CNT_W-1:0] c_val;

  // Half-period timer, reused as the guard timer; holds clocks left after the current one.
  cnt_dn #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero_c   (t_zero_c)
  );

  // Period counter holds full periods left after the current one, so n_cycles = max never overflows.
  cnt_dn #(.W(CNT_W)) u_cycles (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (c_load),
    .load_val (c_val),
    .dec      (c_dec),
    .zero_c   (c_zero_c)
  );

`ifdef PING_DEADTIME_EN
  localparam int unsigned DEAD_W = $clog2(DEAD_CYC + 2);
  logic [DEAD_W-1:0] dead_q, dead_d;
`endif

  always_comb begin
    state_d   = state_q;
    phase_b_d = phase_b_q;
    hp_d      = hp_q;
    guard_d   = guard_q;
    done_d    = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    t_dec     = 1'b0;
    c_load    = 1'b0;
    c_val     = '0;
    c_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          hp_d    = (bus.half_period == '0) ? CNT_W'(1) : bus.half_period;
          guard_d = bus.guard;
          if (bus.n_cycles != '0) begin
            state_d   = ST_BURST;
            phase_b_d = 1'b0;
            t_load    = 1'b1;
            t_val     = hp_d - CNT_W'(1);
            c_load    = 1'b1;
            c_val     = bus.n_cycles - CNT_W'(1);
          end else if (bus.guard != '0) begin
            state_d = ST_GUARD;
            t_load  = 1'b1;
            t_val   = bus.guard - CNT_W'(1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (!t_zero_c) begin
          t_dec = 1'b1;
        end else if (phase_b_q && c_zero_c) begin
          if (guard_q != '0) begin
            state_d = ST_GUARD;
            t_load  = 1'b1;
            t_val   = guard_q - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          phase_b_d = ~phase_b_q;
          t_load    = 1'b1;
          t_val     = hp_q - CNT_W'(1);
          c_dec     = phase_b_q;
        end
      end
      ST_GUARD: begin
        if (t_zero_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d  = (state_d != ST_IDLE);
    drv_a_d = (state_d == ST_BURST) && !phase_b_d;
    drv_b_d = (state_d == ST_BURST) &&  phase_b_d;

`ifdef PING_DEADTIME_EN
    // Dead window restarts whenever the next cycle opens a new half-period.
    if (t_load && (state_d == ST_BURST)) begin
      dead_d = DEAD_W'(DEAD_CYC);
    end else begin
      dead_d = (dead_q == '0) ? '0 : dead_q - DEAD_W'(1);
    end
    if (dead_d != '0) begin
      drv_a_d = 1'b0;
      drv_b_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_b_q <= 1'b0;
      hp_q      <= '0;
      guard_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drv_a_q   <= 1'b0;
      drv_b_q   <= 1'b0;
`ifdef PING_DEADTIME_EN
      dead_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_b_q <= phase_b_d;
      hp_q      <= hp_d;
      guard_q   <= guard_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drv_a_q   <= drv_a_d;
      drv_b_q   <= drv_b_d;
`ifdef PING_DEADTIME_EN
      dead_q    <= dead_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.drv_a = drv_a_q;
  assign bus.drv_b = drv_b_q;

endmodule
